// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 slave memory model for cache-hierarchy benches. INCR bursts only,
//   full-width beats, ID echo, up to MAX_OUTSTANDING queued reads served in
//   order with a fixed READ_LATENCY from AR handshake to first beat.
//   Backing store is DEPTH_LINES lines of DATA_WIDTH bits. A line that was
//   never written returns {(DATA_WIDTH/64){64'(line_index*BYTES)}}.
//   Out-of-range reads return zero data with DECERR; out-of-range writes
//   are dropped silently and still answered OKAY.
//
// Optional build macro:
//   AXI_MEM_PERF_CNT_EN  adds saturating 32-bit counters rd_beat_count,
//                        wr_beat_count and decerr_count.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   arvalid/arready/arid/araddr/arlen          read address channel
//   rvalid/rready/rid/rdata/rresp/rlast        read data channel (registered)
//   awvalid/awready/awid/awaddr/awlen          write address channel
//   wvalid/wready/wdata/wstrb                  write data channel
//   bvalid/bready/bid                          write response channel
module axi_mem_responder #(
  parameter int  ADDR_WIDTH      = 64,
  parameter int  DATA_WIDTH      = 512,
  parameter int  ID_WIDTH        = 8,
  parameter int  DEPTH_LINES     = 1024,
  parameter int  READ_LATENCY    = 4,
  parameter int  MAX_OUTSTANDING = 4,
  localparam int BYTES           = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  arvalid,
  output logic                  arready,
  input  logic [ID_WIDTH-1:0]   arid,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]            arlen,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [ID_WIDTH-1:0]   rid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [ID_WIDTH-1:0]   awid,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]            awlen,
  input  logic                  wvalid,
  output logic                  wready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [BYTES-1:0]      wstrb,
  output logic                  bvalid,
  input  logic                  bready,
  output logic [ID_WIDTH-1:0]   bid
`ifdef AXI_MEM_PERF_CNT_EN
  ,
  output logic [31:0]           rd_beat_count,
  output logic [31:0]           wr_beat_count,
  output logic [31:0]           decerr_count
`endif
);

  localparam int SHIFT = $clog2(BYTES);
  localparam int IDX_W = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef logic [ADDR_WIDTH-1:0] line_t;

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    line_t               line;
    logic [7:0]          len;
    logic [31:0]         due;
  } rd_req_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic in_range(input line_t line);
    return line < line_t'(DEPTH_LINES);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] fill_pattern(input line_t line);
    logic [63:0] word;
    word = 64'(line << SHIFT);
    return {(DATA_WIDTH / 64){word}};
  endfunction

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [DEPTH_LINES];
  logic [DEPTH_LINES-1:0] written;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  rd_req_t           rq [MAX_OUTSTANDING];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr, cand_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        beat_cnt;   // beats of the head burst already loaded
  logic [31:0]       now;        // free-running cycle stamp for due times
  logic              active;     // low only until the first edge after reset

  rd_req_t               cand;
  logic [7:0]            cand_beat;
  line_t                 cand_line;
  logic                  cand_exists, due_ok, last_pending;
  logic                  r_hs, load, enq, deq;
  logic [31:0]           due_diff;
  logic [DATA_WIDTH-1:0] beat_data;
  logic [IDX_W-1:0]      rd_idx;

  // The head's final beat sitting in the output register means the head is
  // fully loaded; the candidate is then the next burst so it can follow the
  // rlast handshake without a bubble. The head itself leaves the queue only
  // on that handshake, so arready reflects bursts not yet fully delivered.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    last_pending = rvalid && rlast;
    cand_ptr     = last_pending ? ptr_inc(rd_ptr) : rd_ptr;
    cand_beat    = last_pending ? 8'd0 : beat_cnt;
    cand_exists  = last_pending ? (count > CNT_W'(1)) : (count != '0);
    cand         = rq[cand_ptr];
    cand_line    = cand.line + line_t'(cand_beat);
    due_diff     = now - cand.due;
    due_ok       = !due_diff[31];
    r_hs         = rvalid && rready;
    load         = (!rvalid || rready) && cand_exists && due_ok;
    deq          = r_hs && rlast;
    enq          = arvalid && arready;
    rd_idx       = cand_line[IDX_W-1:0];
    beat_data    = '0;
    if (in_range(cand_line)) begin
      beat_data = written[rd_idx] ? mem[rd_idx] : fill_pattern(cand_line);
    end
  end

  assign arready = active && (count < CNT_W'(MAX_OUTSTANDING));

  // NOTE: queue payload and the backing store carry no reset; only the
  // pointers, count and written bits need one to make them logically empty.
  always_ff @(posedge clk) begin
    if (enq) begin
      rq[wr_ptr] <= '{id: arid, line: line_t'(araddr >> SHIFT), len: arlen,
                      due: now + 32'(READ_LATENCY)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active   <= 1'b0;
      now      <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      beat_cnt <= '0;
      rvalid   <= 1'b0;
      rid      <= '0;
      rdata    <= '0;
      rresp    <= RESP_OKAY;
      rlast    <= 1'b0;
    end else begin
      active <= 1'b1;
      now    <= now + 32'd1;
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(enq) - CNT_W'(deq);

      if (load) begin
        rvalid   <= 1'b1;
        rid      <= cand.id;
        rlast    <= (cand_beat == cand.len);
        rdata    <= beat_data;
        rresp    <= in_range(cand_line) ? RESP_OKAY : RESP_DECERR;
        beat_cnt <= cand_beat + 8'd1;
      end else begin
        if (r_hs) rvalid <= 1'b0;
        if (deq)  beat_cnt <= '0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t              w_state, w_state_n;
  logic [ID_WIDTH-1:0]   aw_id;
  line_t                 aw_line, w_line;
  logic [7:0]            aw_len, w_beat;
  logic                  aw_hs, w_hs, w_last, w_commit;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_base, w_merged;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_state_n;
  end

  always_comb begin
    w_state_n = w_state;
    case (w_state)
      W_IDLE:  if (aw_hs)             w_state_n = W_DATA;
      W_DATA:  if (w_hs && w_last)    w_state_n = W_RESP;
      W_RESP:  if (bready)            w_state_n = W_IDLE;
      default:                        w_state_n = W_IDLE;
    endcase
  end

  always_comb begin
    awready = active && (w_state == W_IDLE);
    wready  = (w_state == W_DATA);
    bvalid  = (w_state == W_RESP);
  end

  assign bid    = aw_id;
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign w_last = (w_beat == aw_len);
  assign w_line = aw_line + line_t'(w_beat);
  assign w_idx  = w_line[IDX_W-1:0];
  // A beat with no enabled bytes leaves the line untouched and unwritten.
  assign w_commit = w_hs && in_range(w_line) && (|wstrb);

  // Partial writes to a never-written line merge into its address pattern so
  // the untouched bytes read back exactly as they did before the write.
  always_comb begin
    w_base   = written[w_idx] ? mem[w_idx] : fill_pattern(w_line);
    w_merged = w_base;
    for (int b = 0; b < BYTES; b++) begin
      if (wstrb[b]) w_merged[b*8 +: 8] = wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_id   <= '0;
      aw_line <= '0;
      aw_len  <= '0;
      w_beat  <= '0;
      written <= '0;
    end else begin
      if (aw_hs) begin
        aw_id   <= awid;
        aw_line <= line_t'(awaddr >> SHIFT);
        aw_len  <= awlen;
        w_beat  <= '0;
      end else if (w_hs) begin
        w_beat <= w_beat + 8'd1;
      end
      if (w_commit) written[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_commit) mem[w_idx] <= w_merged;
  end

`ifdef AXI_MEM_PERF_CNT_EN
  // ---------------------------------------------------------------------------
  // Saturating performance counters, counted on channel handshakes.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_beat_count <= '0;
      wr_beat_count <= '0;
      decerr_count  <= '0;
    end else begin
      if (r_hs && rd_beat_count != '1) rd_beat_count <= rd_beat_count + 32'd1;
      if (w_hs && wr_beat_count != '1) wr_beat_count <= wr_beat_count + 32'd1;
      if (r_hs && rresp == RESP_DECERR && decerr_count != '1)
        decerr_count <= decerr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder
//   Directed bench for axi_mem_responder with default parameters. Stimulus
//   tasks push expected R beats and B IDs into queues; a negedge monitor pops
//   and compares on every R/B handshake.
module tb_axi_mem_responder;
  localparam int AW    = 64;
  localparam int DW    = 512;
  localparam int IW    = 8;
  localparam int DEPTH = 1024;
  localparam int LAT   = 4;
  localparam int MAXO  = 4;
  localparam int NB    = DW / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          arvalid, arready;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic          rvalid, rready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          awvalid, awready;
  logic [IW-1:0] awid;
  logic [AW-1:0] awaddr;
  logic [7:0]    awlen;
  logic          wvalid, wready;
  logic [DW-1:0] wdata;
  logic [NB-1:0] wstrb;
  logic          bvalid, bready;
  logic [IW-1:0] bid;
`ifdef AXI_MEM_PERF_CNT_EN
  logic [31:0]   rd_beat_count, wr_beat_count, decerr_count;
`endif

  axi_mem_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .DEPTH_LINES(DEPTH),
    .READ_LATENCY(LAT), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk(clk), .rst(rst),
    .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
    .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bid(bid)
`ifdef AXI_MEM_PERF_CNT_EN
    , .rd_beat_count(rd_beat_count), .wr_beat_count(wr_beat_count),
    .decerr_count(decerr_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [IW-1:0] id;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic          last;
  } r_exp_t;

  r_exp_t        exp_r[$];
  logic [IW-1:0] exp_b[$];
  r_exp_t        mon_e;
  logic [IW-1:0] mon_b;
  int            checks = 0;
  int            errors = 0;

  logic [DW-1:0] data_a, data_b, data_p, exp_d;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [63:0] byte_addr);
    return {(DW / 64){byte_addr}};
  endfunction

  // Scoreboard monitor: compare on every handshake, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && rvalid && rready) begin
      if (exp_r.size() == 0) check("r_unexpected_beat", DW'(rvalid), '0);
      else begin
        mon_e = exp_r.pop_front();
        check("rid",   DW'(rid),   DW'(mon_e.id));
        check("rdata", rdata,      mon_e.data);
        check("rresp", DW'(rresp), DW'(mon_e.resp));
        check("rlast", DW'(rlast), DW'(mon_e.last));
      end
    end
    if (!rst && bvalid && bready) begin
      if (exp_b.size() == 0) check("b_unexpected", DW'(bvalid), '0);
      else begin
        mon_b = exp_b.pop_front();
        check("bid", DW'(bid), DW'(mon_b));
      end
    end
  end

  task automatic push_r(input logic [IW-1:0] id, input logic [DW-1:0] d,
                        input logic [1:0] resp, input logic last);
    r_exp_t e;
    e.id = id; e.data = d; e.resp = resp; e.last = last;
    exp_r.push_back(e);
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                         input logic [7:0] len, output int hs_cyc);
    arvalid = 1'b1; arid = id; araddr = addr; arlen = len;
    hs_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (arready) begin
        hs_cyc = cyc + 1;
        break;
      end
    end
    if (hs_cyc < 0) check("ar_timeout", DW'(arready), DW'(1));
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    bit ok = 0;
    awvalid = 1'b1; awid = id; awaddr = addr; awlen = len;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1; break; end
    end
    if (!ok) check("aw_timeout", DW'(awready), DW'(1));
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [NB-1:0] strb);
    bit ok = 0;
    wvalid = 1'b1; wdata = d; wstrb = strb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1; break; end
    end
    if (!ok) check("w_timeout", DW'(wready), DW'(1));
    @(posedge clk); #1;
    wvalid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_r.size() == 0 && exp_b.size() == 0) break;
    end
    check("drain_r", DW'(exp_r.size()), '0);
    check("drain_b", DW'(exp_b.size()), '0);
    @(posedge clk); #1;
  endtask

  int hs, seen, first_cyc;

  initial begin
    rst = 1'b1;
    arvalid = 0; arid = 0; araddr = 0; arlen = 0; rready = 1'b1;
    awvalid = 0; awid = 0; awaddr = 0; awlen = 0;
    wvalid = 0; wdata = 0; wstrb = 0; bready = 1'b1;
    data_a = {8{64'h1111_2222_3333_4444}};
    data_b = {8{64'h5555_6666_7777_8888}};

    // Reset state: every output low while rst is held.
    repeat (2) @(negedge clk);
    check("rst_arready", DW'(arready), '0);
    check("rst_awready", DW'(awready), '0);
    check("rst_wready",  DW'(wready),  '0);
    check("rst_rvalid",  DW'(rvalid),  '0);
    check("rst_bvalid",  DW'(bvalid),  '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("arready_out_of_rst", DW'(arready), DW'(1));
    check("awready_out_of_rst", DW'(awready), DW'(1));
    @(posedge clk); #1;

    // Two-beat write then two-beat read of lines 1 and 2.
    exp_b.push_back(8'h21);
    send_aw(8'h21, 64'h40, 8'd1);
    send_w(data_a, '1);
    send_w(data_b, '1);
    wait_idle();
    push_r(8'h31, data_a, 2'b00, 1'b0);
    push_r(8'h31, data_b, 2'b00, 1'b1);
    send_ar(8'h31, 64'h40, 8'd1, hs);
    wait_idle();

    // Unwritten line: address pattern, first beat exactly LAT cycles after AR.
    push_r(8'h42, {8{64'h1000}}, 2'b00, 1'b1);
    send_ar(8'h42, 64'h1000, 8'd0, hs);
    first_cyc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rvalid) begin first_cyc = cyc; break; end
    end
    check("rd_latency", DW'(first_cyc), DW'(hs + LAT));
    wait_idle();

    // Outstanding limit: four accepted with rready low, fifth stalls.
    rready = 1'b0;
    for (int i = 1; i <= MAXO; i++) begin
      push_r(IW'(i), pat(64'h2000 + 64'((i - 1) * 64)), 2'b00, 1'b1);
      send_ar(IW'(i), 64'h2000 + 64'((i - 1) * 64), 8'd0, hs);
    end
    push_r(8'd5, pat(64'h2100), 2'b00, 1'b1);
    arvalid = 1'b1; arid = 8'd5; araddr = 64'h2100; arlen = 8'd0;
    repeat (6) @(negedge clk);
    check("arready_full", DW'(arready), '0);
    check("rid_held_head", DW'(rid), DW'(1));
    check("rvalid_held", DW'(rvalid), DW'(1));
    @(posedge clk); #1 rready = 1'b1;
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (arready) begin seen = 1; break; end
    end
    check("ar5_accepted", DW'(seen), DW'(1));
    @(posedge clk); #1 arvalid = 1'b0;
    wait_idle();

    // Range boundary: last line OKAY, next beat DECERR with zero data.
    push_r(8'h55, {8{64'hFFC0}}, 2'b00, 1'b0);
    push_r(8'h55, '0, 2'b11, 1'b1);
    send_ar(8'h55, 64'hFFC0, 8'd1, hs);
    push_r(8'h56, '0, 2'b11, 1'b1);
    send_ar(8'h56, 64'(DEPTH * NB), 8'd0, hs);
    wait_idle();

    // Out-of-range write dropped but answered; wstrb=0 leaves line unwritten.
    exp_b.push_back(8'h60);
    send_aw(8'h60, 64'(DEPTH * NB), 8'd0);
    send_w(data_a, '1);
    exp_b.push_back(8'h61);
    send_aw(8'h61, 64'h3000, 8'd0);
    send_w(data_a, '0);
    wait_idle();
    push_r(8'h62, {8{64'h3000}}, 2'b00, 1'b1);
    send_ar(8'h62, 64'h3000, 8'd0, hs);
    wait_idle();

    // Single-byte write (low address bits ignored) changes only byte 0.
    exp_b.push_back(8'h70);
    send_aw(8'h70, 64'h47, 8'd0);
    send_w({8{64'h0123_4567_89AB_CDEE}}, NB'(1));
    wait_idle();
    exp_d = data_a;
    exp_d[7:0] = 8'hEE;
    push_r(8'h71, exp_d, 2'b00, 1'b1);
    send_ar(8'h71, 64'h40, 8'd0, hs);
    wait_idle();

    // Reset during beat 2 of a four-beat burst.
    exp_b.push_back(8'h07);
    send_aw(8'h07, 64'h5000, 8'd0);
    send_w(data_b, '1);
    wait_idle();
    push_r(8'h09, data_b, 2'b00, 1'b0);
    push_r(8'h09, {8{64'h5040}}, 2'b00, 1'b0);
    send_ar(8'h09, 64'h5000, 8'd3, hs);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (exp_r.size() == 0) break;
    end
    rst = 1'b1;
    @(negedge clk);
    check("rvalid_abort", DW'(rvalid), '0);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("arready_after_rst", DW'(arready), DW'(1));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvalid) seen++;
    end
    check("no_beats_after_rst", DW'(seen), '0);
    @(posedge clk); #1;
    push_r(8'h0A, {8{64'h5000}}, 2'b00, 1'b1);
    send_ar(8'h0A, 64'h5000, 8'd0, hs);
    push_r(8'h0B, {8{64'h0040}}, 2'b00, 1'b1);
    send_ar(8'h0B, 64'h40, 8'd0, hs);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
